// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg
//   Shared types and constants for the add-shift multiplier sequencer.
//   - N_BITS_DEFAULT : default multiplier width / iteration count
//   - mult_state_t   : controller state encoding
package mult_ctrl_pkg;

   localparam int unsigned N_BITS_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      ADD,
      SHIFT,
      HALT
   } mult_state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// mult_iter_counter
//   Iteration counter for the add-shift sequence. It counts completed
//   SHIFT cycles and flags the final iteration.
//   Ports:
//     i_clk   : system clock
//     i_reset : synchronous active-high reset
//     i_clear : zero the count this edge
//     i_incr  : advance the count this edge
//     o_last  : count equals N_BITS-1
module mult_iter_counter
   import mult_ctrl_pkg::*;
#(
   parameter int unsigned N_BITS = N_BITS_DEFAULT
)(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_incr,
   output logic o_last
);

   localparam int unsigned    CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_cnt <= '0;
      end else if (i_incr) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/mult_control_unit.sv
// mult_control_unit
//   Sequencer for the 8-bit signed add-shift multiplier datapath. A Run
//   request clears A/X, then performs N_BITS add(or sub)/shift iterations
//   and parks in HALT until Run is released.
//   Ports:
//     Clk          : system clock
//     Reset        : synchronous active-high reset
//     Run          : start request (level)
//     ClearA_LoadB : clear A/X and load B request (honoured in IDLE only)
//     M            : multiplier LSB B[0] from the datapath
//     ClearA       : clear A and X strobe
//     LoadB        : load B from switches strobe
//     Add          : A:X <= A + S strobe
//     Sub          : A:X <= A - S strobe
//     Shift        : arithmetic right shift of X:A:B strobe
//     Busy         : high from CLR through the final SHIFT
//     Done         : high while in HALT
module mult_control_unit
   import mult_ctrl_pkg::*;
#(
   parameter int unsigned N_BITS = N_BITS_DEFAULT
)(
   input  logic Clk,
   input  logic Reset,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic ClearA,
   output logic LoadB,
   output logic Add,
   output logic Sub,
   output logic Shift,
   output logic Busy,
   output logic Done
);

   mult_state_t r_state;
   mult_state_t w_next;
   logic        w_last;
   logic        w_cnt_clear;
   logic        w_cnt_incr;

   mult_iter_counter #(
      .N_BITS (N_BITS)
   ) u_iter_counter (
      .i_clk   (Clk),
      .i_reset (Reset),
      .i_clear (w_cnt_clear),
      .i_incr  (w_cnt_incr),
      .o_last  (w_last)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_cnt_clear = 1'b0;
      w_cnt_incr  = 1'b0;
      ClearA      = 1'b0;
      LoadB       = 1'b0;
      Add         = 1'b0;
      Sub         = 1'b0;
      Shift       = 1'b0;
      Busy        = 1'b0;
      Done        = 1'b0;

      unique case (r_state)
         IDLE: begin
            ClearA = ClearA_LoadB;
            LoadB  = ClearA_LoadB;
            if (Run) begin
               w_next = CLR;
            end
         end
         CLR: begin
            Busy        = 1'b1;
            ClearA      = 1'b1;
            w_cnt_clear = 1'b1;
            w_next      = ADD;
         end
         ADD: begin
            Busy = 1'b1;
            // The multiplier MSB has negative weight, so the last
            // partial product is subtracted.
            if (M) begin
               if (w_last) begin
                  Sub = 1'b1;
               end else begin
                  Add = 1'b1;
               end
            end
            w_next = SHIFT;
         end
         SHIFT: begin
            Busy  = 1'b1;
            Shift = 1'b1;
            if (w_last) begin
               w_next = HALT;
            end else begin
               w_cnt_incr = 1'b1;
               w_next     = ADD;
            end
         end
         HALT: begin
            Done = 1'b1;
            if (!Run) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mult_control_unit.sv
// tb_mult_control_unit
//   Scoreboard bench for mult_control_unit. Expected per-cycle output
//   vectors {ClearA,LoadB,Add,Sub,Shift,Busy,Done} are queued when a run
//   is launched and compared cycle by cycle on the falling edge. M comes
//   from a small model of the B shift register.
module tb_mult_control_unit;

   logic clk;
   logic rst;
   logic run;
   logic clb;
   logic m;
   logic clear_a, load_b, add, sub, shift, busy, done;

   logic [7:0] sw;
   logic [7:0] b_model;

   logic [6:0] exp_q[$];
   int unsigned n_checks;
   int unsigned n_errors;
   int unsigned n_add, n_sub, n_shift;

   mult_control_unit #(
      .N_BITS (8)
   ) dut (
      .Clk          (clk),
      .Reset        (rst),
      .Run          (run),
      .ClearA_LoadB (clb),
      .M            (m),
      .ClearA       (clear_a),
      .LoadB        (load_b),
      .Add          (add),
      .Sub          (sub),
      .Shift        (shift),
      .Busy         (busy),
      .Done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // B register model: load from switches, shift right on Shift.
   always @(posedge clk) begin
      if (load_b) begin
         b_model <= sw;
      end else if (shift) begin
         b_model <= {b_model[7], b_model[7:1]};
      end
   end
   assign m = b_model[0];

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [6:0] ov(input logic ca, input logic lb,
                                     input logic ad, input logic sb,
                                     input logic sh, input logic bz,
                                     input logic dn);
      return {ca, lb, ad, sb, sh, bz, dn};
   endfunction

   // Scoreboard consumer.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [6:0] e;
         e = exp_q.pop_front();
         check_val("outputs", {25'd0, clear_a, load_b, add, sub, shift, busy, done},
                   {25'd0, e});
      end
      n_add   += (add === 1'b1)   ? 1 : 0;
      n_sub   += (sub === 1'b1)   ? 1 : 0;
      n_shift += (shift === 1'b1) ? 1 : 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue the first n vectors of a run: CLR, then ADD/SHIFT pairs.
   task automatic push_seq(input logic [7:0] b, input int unsigned n);
      logic [6:0] v[$];
      v.push_back(ov(1, 0, 0, 0, 0, 1, 0));
      for (int unsigned i = 0; i < 8; i++) begin
         v.push_back(ov(0, 0, b[i] && (i < 7), b[i] && (i == 7), 0, 1, 0));
         v.push_back(ov(0, 0, 0, 0, 1, 1, 0));
      end
      for (int unsigned i = 0; i < n; i++) begin
         exp_q.push_back(v[i]);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      check_val("drain", exp_q.size(), 0);
   endtask

   // Launch a run with multiplier b; Run held for `hold` cycles from the
   // launch cycle; optionally pulse ClearA_LoadB while busy.
   task automatic do_run(input logic [7:0] b, input int unsigned hold,
                         input logic clb_busy);
      int unsigned a0, s0, h0;
      int unsigned c;
      tick();
      a0 = n_add; s0 = n_sub; h0 = n_shift;
      sw  = b;
      clb = 1'b1;
      run = 1'b1;
      exp_q.push_back(ov(1, 1, 0, 0, 0, 0, 0));
      push_seq(b, 17);
      for (c = 1; c <= 17; c++) begin
         tick();
         clb = clb_busy && (c == 5 || c == 6);
         run = (c < hold);
      end
      c = 18;
      do begin
         tick();
         clb = clb_busy;
         run = (c < hold);
         exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 1));
         c++;
      end while (run);
      tick();
      clb = 1'b0;
      exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0));
      wait_drain();
      check_val("shift_count", n_shift - h0, 8);
      check_val("add_count", n_add - a0, $countones(b[6:0]));
      check_val("sub_count", n_sub - s0, b[7]);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      n_add = 0; n_sub = 0; n_shift = 0;
      rst = 1'b1;
      run = 1'b0;
      clb = 1'b0;
      sw  = 8'h00;
      repeat (2) @(posedge clk);

      // Reset held: outputs idle, ClearA/LoadB still follow the request.
      tick();
      exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0));
      tick();
      clb = 1'b1;
      exp_q.push_back(ov(1, 1, 0, 0, 0, 0, 0));
      tick();
      clb = 1'b0;
      rst = 1'b0;
      exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0));

      // Single-cycle ClearA_LoadB pulse in IDLE.
      tick();
      sw  = 8'h3C;
      clb = 1'b1;
      exp_q.push_back(ov(1, 1, 0, 0, 0, 0, 0));
      tick();
      clb = 1'b0;
      exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0));
      tick();
      exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0));
      wait_drain();

      do_run(8'hFF, 1, 1'b0);
      do_run(8'h00, 1, 1'b0);
      do_run(8'hA5, 1, 1'b0);
      do_run(8'h81, 40, 1'b1);
      do_run(8'h36, 2, 1'b0);

      // Reset during the 4th SHIFT aborts the run.
      tick();
      sw  = 8'hA5;
      clb = 1'b1;
      run = 1'b1;
      exp_q.push_back(ov(1, 1, 0, 0, 0, 0, 0));
      push_seq(8'hA5, 9);
      for (int unsigned c = 1; c <= 8; c++) begin
         tick();
         clb = 1'b0;
         run = 1'b0;
      end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0));
      tick();
      exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0));
      wait_drain();

      do_run(8'h5A, 3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
